// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 target that receives MSB-first bytes. MISO returns
// a byte that is loaded when chip select falls. The SPI pins are oversampled
// in the clk domain. Every completed byte is reported with a one-cycle valid
// pulse and is folded into a running XOR/popcount checksum.
//
// Optional build macro: SPI_SLAVE_ABORT_CNT_EN adds an abort_count output and
// an aborted output.
//
// Ports:
//   clk, rst     system clock; synchronous, active-high reset
//   sclk_in      SPI clock from the master (asynchronous)
//   cs_n_in      SPI chip select, active low (asynchronous)
//   mosi_in      SPI data from the master (asynchronous)
//   tx_data      byte returned on miso; captured when cs_n falling is seen
//   miso_out     SPI data to the master (registered; 0 when idle)
//   rx_data      last completed received byte
//   rx_valid     one-cycle pulse; rx_data is new this cycle
//   busy         high while in RECV or DONE
//   result       running checksum: ^= byte ^ popcount(byte)
//   abort_count  (macro only) saturating count of aborted frames
//   aborted      (macro only) one-cycle pulse while in ABORT
//
// state | meaning
// IDLE  | waiting for chip select to fall; miso held at 0
// RECV  | shifting bits on synchronized sclk edges
// DONE  | one cycle: byte reported, checksum updated
// ABORT | one cycle: frame ended mid-byte, partial byte dropped

module spi_slave_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk_in,
  input  logic        cs_n_in,
  input  logic        mosi_in,
  input  logic [7:0]  tx_data,
  output logic        miso_out,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic [31:0] result
`ifdef SPI_SLAVE_ABORT_CNT_EN
  ,
  output logic [7:0]  abort_count,
  output logic        aborted
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_d1_q, cs_d1_q;
  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        miso_q, miso_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  pop;
  logic        last_bit;

  // Chip select idles high, so its chain resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_d1_q   <= 1'b0;
      cs_d1_q     <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
      sclk_d1_q   <= sclk_s;
      cs_d1_q     <= cs_n_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s & sclk_d1_q;
  assign cs_fall   = ~cs_n_s & cs_d1_q;
  assign cs_rise   = cs_n_s & ~cs_d1_q;

  // The 8th rising edge wins over a simultaneous chip-select release.
  assign last_bit = sclk_rise && (bit_cnt_q == 3'd7);

  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++) pop = pop + {3'd0, rx_data_q[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      miso_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      miso_q     <= miso_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      result_q   <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = RECV;
          bit_cnt_d  = '0;
          shift_d    = '0;
          tx_shift_d = tx_data;
          miso_d     = tx_data[7];
        end
      end
      RECV: begin
        if (sclk_fall) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
          miso_d     = tx_shift_q[6];
        end
        if (sclk_rise) begin
          shift_d   = {shift_q[6:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (last_bit) begin
          // rx_valid is registered so it coincides with the DONE cycle.
          state_d    = DONE;
          rx_valid_d = 1'b1;
          rx_data_d  = {shift_q[6:0], mosi_s};
        end else if (cs_rise) begin
          state_d = ABORT;
          miso_d  = 1'b0;
        end
      end
      DONE: begin
        result_d = result_q ^ {24'd0, rx_data_q} ^ {28'd0, pop};
        if (!cs_n_s) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end else begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      end
      ABORT: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign miso_out = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q == RECV) || (state_q == DONE);
  assign result   = result_q;

`ifdef SPI_SLAVE_ABORT_CNT_EN
  logic [7:0] abort_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) abort_cnt_q <= '0;
    else if (state_q == ABORT && abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'd1;
  end

  assign abort_count = abort_cnt_q;
  assign aborted     = (state_q == ABORT);
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk_in = 1'b0;
  logic        cs_n_in = 1'b1;
  logic        mosi_in = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        miso_out;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        busy;
  logic [31:0] result;
`ifdef SPI_SLAVE_ABORT_CNT_EN
  logic [7:0]  abort_count;
  logic        aborted;
`endif

  spi_slave_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .cs_n_in(cs_n_in), .mosi_in(mosi_in),
    .tx_data(tx_data), .miso_out(miso_out), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .result(result)
`ifdef SPI_SLAVE_ABORT_CNT_EN
    , .abort_count(abort_count), .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: records every rx_valid byte and the result one cycle later.
  int          v_cnt = 0;
  int          r_cnt = 0;
  int          ab_cnt = 0;
  logic        pending = 1'b0;
  logic [7:0]  v_data [32];
  logic [31:0] v_res  [32];

  always @(negedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else begin
      pending <= rx_valid;
      if (rx_valid) begin
        v_data[v_cnt % 32] <= rx_data;
        v_cnt <= v_cnt + 1;
      end
      if (pending) begin
        v_res[r_cnt % 32] <= result;
        r_cnt <= r_cnt + 1;
      end
`ifdef SPI_SLAVE_ABORT_CNT_EN
      if (aborted) ab_cnt <= ab_cnt + 1;
`endif
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; cs_n_in = 1'b1; sclk_in = 1'b0; mosi_in = 1'b0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(6);
  endtask

  // One SPI bit: set mosi, hold low phase, sample miso as the master would, rise.
  // With end_frame the chip select is released on the same edge as sclk rises.
  task automatic send_bit(input logic b, input logic end_frame, output logic m);
    mosi_in = b;
    wait_clk(HALF);
    m = miso_out;
    sclk_in = 1'b1;
    if (end_frame) cs_n_in = 1'b1;
    wait_clk(HALF);
    sclk_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic end_frame, output logic [7:0] m);
    logic mb;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], end_frame && (i == 0), mb);
      m[i] = mb;
    end
  endtask

  typedef struct {
    logic        do_rst;
    logic [7:0]  tx;
    logic [7:0]  mosi;
    logic [7:0]  exp_rx;
    logic [31:0] exp_res;
    logic [7:0]  exp_miso;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [7:0] m8;
    logic       mb;
    int         base;

    vecs[0] = '{1'b1, 8'h00, 8'hA5, 8'hA5, 32'h000000A1, 8'h00};
    vecs[1] = '{1'b0, 8'h5A, 8'h3C, 8'h3C, 32'h00000099, 8'h5A};
    vecs[2] = '{1'b1, 8'hC3, 8'h00, 8'h00, 32'h00000000, 8'hC3};
    vecs[3] = '{1'b0, 8'h96, 8'h81, 8'h81, 32'h00000083, 8'h96};

    wait_clk(3);
    check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset miso", {31'd0, miso_out}, 32'd0);
    check("reset rx_data", {24'd0, rx_data}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;
    wait_clk(6);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].do_rst) do_reset();
      base = v_cnt;
      tx_data = vecs[v].tx;
      cs_n_in = 1'b0;
      wait_clk(HALF);
      check("busy in frame", {31'd0, busy}, 32'd1);
      send_byte(vecs[v].mosi, 1'b0, m8);
      wait_clk(HALF);
      cs_n_in = 1'b1;
      wait_clk(12);
      check("vec pulse count", v_cnt - base, 32'd1);
      check("vec rx_data", {24'd0, v_data[base % 32]}, {24'd0, vecs[v].exp_rx});
      check("vec result", v_res[base % 32], vecs[v].exp_res);
      check("vec miso bits", {24'd0, m8}, {24'd0, vecs[v].exp_miso});
      check("vec busy after", {31'd0, busy}, 32'd0);
      check("vec miso idle", {31'd0, miso_out}, 32'd0);
    end

    // Back-to-back bytes in one frame.
    do_reset();
    base = v_cnt;
    tx_data = 8'h00;
    cs_n_in = 1'b0;
    wait_clk(HALF);
    send_byte(8'hFF, 1'b0, m8);
    send_byte(8'h00, 1'b0, m8);
    wait_clk(HALF);
    cs_n_in = 1'b1;
    wait_clk(12);
    check("b2b pulse count", v_cnt - base, 32'd2);
    check("b2b byte0", {24'd0, v_data[base % 32]}, 32'h000000FF);
    check("b2b byte1", {24'd0, v_data[(base + 1) % 32]}, 32'h00000000);
    check("b2b result0", v_res[base % 32], 32'h000000F7);
    check("b2b result1", v_res[(base + 1) % 32], 32'h000000F7);
    check("b2b busy after", {31'd0, busy}, 32'd0);

    // Abort after five bits.
    base = v_cnt;
    cs_n_in = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, mb);
    wait_clk(HALF);
    cs_n_in = 1'b1;
    wait_clk(12);
    check("abort no pulse", v_cnt - base, 32'd0);
    check("abort result kept", result, 32'h000000F7);
    check("abort busy", {31'd0, busy}, 32'd0);
`ifdef SPI_SLAVE_ABORT_CNT_EN
    check("abort_count", {24'd0, abort_count}, 32'd1);
    check("aborted pulses", ab_cnt, 32'd1);
`endif

    // Reset in the middle of 0x81, then a clean 0x81 frame.
    base = v_cnt;
    cs_n_in = 1'b0;
    wait_clk(HALF);
    for (int i = 7; i >= 4; i--) send_bit(i == 7, 1'b0, mb);
    do_reset();
    check("midreset result", result, 32'd0);
`ifdef SPI_SLAVE_ABORT_CNT_EN
    check("midreset abort_count", {24'd0, abort_count}, 32'd0);
`endif
    cs_n_in = 1'b0;
    wait_clk(HALF);
    send_byte(8'h81, 1'b0, m8);
    wait_clk(HALF);
    cs_n_in = 1'b1;
    wait_clk(12);
    check("midreset pulse count", v_cnt - base, 32'd1);
    check("midreset rx_data", {24'd0, v_data[base % 32]}, 32'h00000081);
    check("midreset result after", v_res[base % 32], 32'h00000083);

    // 8th rising edge coincident with cs_n release.
    base = v_cnt;
    cs_n_in = 1'b0;
    wait_clk(HALF);
    send_byte(8'h5A, 1'b1, m8);
    wait_clk(12);
    check("coinc pulse count", v_cnt - base, 32'd1);
    check("coinc rx_data", {24'd0, v_data[base % 32]}, 32'h0000005A);
    check("coinc result", v_res[base % 32], 32'h000000DD);
    check("coinc busy", {31'd0, busy}, 32'd0);
    check("coinc miso idle", {31'd0, miso_out}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI mode-0 target (slave) that receives MSB-first bytes from the team's SPI master over external sclk/cs_n/mosi pins.
- Drives miso from a byte loaded when cs_n falls.
- Oversamples the SPI pins in the clk domain through synchronizers and edge detection.
- Reports each received byte with a one-cycle valid pulse and keeps a running XOR/popcount checksum on result, for cross-checking against the master-side checksum.

Parameters:
SYNC_STAGES, 2, number of flops in each input synchronizer chain (legal 2..4)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
sclk_in  input  1  SPI clock from master, asynchronous to clk
cs_n_in  input  1  SPI chip select, active-low, asynchronous
mosi_in  input  1  SPI data from master, asynchronous
tx_data  input  8  byte returned on miso; sampled on the clk cycle cs_n falling is detected
miso_out  output  1  SPI data to master
rx_data  output  8  last completed received byte
rx_valid  output  1  one-cycle pulse; rx_data is new this cycle
busy  output  1  high while in RECV or DONE
result  output  32  running checksum

Behaviour:
- Synchronization:
  - Each of sclk_in, cs_n_in and mosi_in passes through SYNC_STAGES flops.
  - A further registered copy of sclk_s and cs_n_s gives edge detection: sclk_rise, sclk_fall, cs_fall, cs_rise.
  - Legal pin timing: sclk high and low phases each ≥ SYNC_STAGES+2 clk cycles; mosi stable around the rising sclk edge.
- FSM states (2-bit enum): IDLE=0, RECV=1, DONE=2, ABORT=3.
  - IDLE: on cs_fall → RECV; bit_cnt=0, shift_reg=0, tx_shift=tx_data, miso_out=tx_data[7].
  - RECV, sclk_rise: shift_reg = {shift_reg[6:0], mosi_s}; bit_cnt+1.
    - If bit_cnt was 7 → DONE.
  - RECV, sclk_fall: tx_shift = {tx_shift[6:0], 1'b0}; miso_out = new tx_shift[7].
  - RECV, cs_rise with no byte completing that cycle → ABORT. The partial byte is discarded.
  - DONE (exactly 1 cycle):
    - rx_valid=1; rx_data=shift_reg.
    - result ^= {24'd0, byte} ^ {28'd0, popcount(byte)}.
    - Next state: if cs_n_s low → RECV with bit_cnt=0 (back-to-back byte; tx_shift keeps shifting zeros). Else → IDLE.
  - ABORT (1 cycle): increments abort counter (feature) → IDLE.
- Simultaneous events:
  - 8th sclk_rise and cs_rise in the same cycle: the byte is accepted (→ DONE), then IDLE.
  - sclk edges while cs_n_s high or in IDLE are ignored.
  - A cs_fall seen during DONE is treated as still selected.
- Outputs:
  - rx_valid is registered. Latency from the synchronized 8th sclk_rise to rx_valid is 1 clk.
  - result update is visible the cycle after rx_valid.
  - miso_out is registered; it holds 0 in IDLE.
- Widths: bit_cnt is 3 bits and wraps 7→0 only via the DONE transition. popcount is 4 bits (0..8).
- Reset (also mid-byte): state=IDLE, rx_data=0, rx_valid=0, busy=0, miso_out=0, result=0, shift_reg=0, bit_cnt=0, synchronizers set to cs_n=1 / sclk=0 / mosi=0.
  - A byte in flight at reset is lost.
  - The master must re-assert cs_n before the next byte is recognized.

Optional Feature:
- Macro: SPI_SLAVE_ABORT_CNT_EN.
- Defined:
  - Adds output port abort_count [7:0], reset 0.
  - Increments in ABORT state and saturates at 8'hFF.
  - Also adds output aborted: 1-cycle pulse coincident with the ABORT state.
- Undefined:
  - Neither port exists.
  - ABORT state still exists and behaves identically.
  - No counter logic is synthesized.

Test Plan:
- Reset, then one framed byte 0xA5 (cs_n low, 8 sclk periods, cs_n high) → single rx_valid pulse with rx_data=0xA5; result=0x000000A1 (0xA5 ^ 4).
- Continue with byte 0x3C in a separate frame → rx_data=0x3C; result=0x00000099 (0xA1 ^ 0x3C ^ 4). busy returns to 0 after the frame.
- Back-to-back in one frame: 0xFF then 0x00 with cs_n held low → two rx_valid pulses (0xFF, then 0x00); result=0x00000000 → 0x000000F7 → 0x000000F7.
- tx_data=0xC3 at cs_n fall, master sends 0x00 → miso_out at the 8 master sampling edges reads 1,1,0,0,0,0,1,1; miso_out=0 after cs_n high.
- Abort: cs_n high after 5 sclk rises → no rx_valid, result unchanged, state returns to IDLE. With SPI_SLAVE_ABORT_CNT_EN: abort_count=1 and one aborted pulse.
- Reset asserted after 4 bits of 0x81, then a fresh frame with 0x81 → only one rx_valid (0x81); result=0x00000083 (0x81 ^ 2). Also check that the 8th sclk rise coincident with cs_n rise still yields rx_valid.
